// File: rtl/ixc_clk_sched_pkg.sv
// ---------------------------------------------------------------------------
// ixc_clk_sched_pkg
//   Shared definitions for the emulated-time clock scheduler: the scheduler
//   state encoding, default widths and the reset half-period.
//   No ports (package).
// ---------------------------------------------------------------------------
package ixc_clk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        APPLY = 2'd3
    } schedState_t;

    localparam int SCHED_HW       = 10;   // half-period / remaining-count width
    localparam int SCHED_DW       = 11;   // step_delta width
    localparam int SCHED_TW       = 48;   // sim_time width
    localparam int SCHED_DEF_HALF = 625;  // reset value of every half-period

    // Width of a clock index; a single clock still gets a 1-bit index port.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ixc_clk_min_tree.sv
// ---------------------------------------------------------------------------
// ixc_clk_min_tree
//   Combinational minimum over the remaining-time counters of the enabled
//   clocks. Disabled entries are treated as all-ones so they never win.
// Ports:
//   remVec  in   NUM_CLKS x HW  remaining time per clock
//   enMask  in   NUM_CLKS       per-clock enable
//   minVal  out  HW             smallest enabled remaining time
//   anyEn   out  1              at least one clock is enabled
// ---------------------------------------------------------------------------
module ixc_clk_min_tree #(
    parameter int NUM_CLKS = 4,
    parameter int HW       = 10
) (
    input  logic [NUM_CLKS-1:0][HW-1:0] remVec,
    input  logic [NUM_CLKS-1:0]         enMask,
    output logic [HW-1:0]               minVal,
    output logic                        anyEn
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned (no latch); blocking '=' is correct here because each
        // iteration must see the running minimum of the previous one.
        minVal = '1;
        anyEn  = 1'b0;
        for (int i = 0; i < NUM_CLKS; i++) begin
            if (enMask[i]) begin
                anyEn = 1'b1;
                if (remVec[i] < minVal) begin
                    minVal = remVec[i];
                end
            end
        end
    end

endmodule

// File: rtl/ixc_clock_scheduler.sv
// ---------------------------------------------------------------------------
// ixc_clock_scheduler
//   Sequences emulated time for NUM_CLKS free-running clocks, each with a
//   programmable half-period. Every step offers the time to the next edge on
//   a valid/ready handshake; once accepted, the clocks whose edge falls at
//   that time toggle and sim_time advances.
//   Optional feature macro: IXC_CLK_SCHED_STOP_EN adds a stop time that clips
//   the step and ends scheduling with a one-cycle stop_hit pulse.
// Ports:
//   eclk         in   emulation clock, all state on posedge
//   rst          in   synchronous active-high reset
//   start        in   begin scheduling (IDLE only)
//   halt_req     in   stop after the current step completes
//   cfg_we       in   half-period write strobe (IDLE only)
//   cfg_idx      in   clock index for the write
//   cfg_half     in   half-period value (0 is stored as 1)
//   cfg_en_mask  in   per-clock enable, sampled on start
//   step_valid   out  step_delta offered
//   step_delta   out  time to the next edge
//   step_ready   in   time-advance accepts the step
//   clk_out      out  scheduled clock levels
//   sim_time     out  accumulated emulated time
//   stop_time    in   (STOP_EN only) time at which scheduling stops
//   stop_hit     out  (STOP_EN only) one-cycle pulse when stop_time is reached
//   running      out  high outside IDLE
// ---------------------------------------------------------------------------
module ixc_clock_scheduler
    import ixc_clk_sched_pkg::*;
#(
    parameter int NUM_CLKS = 4,
    parameter int HW       = SCHED_HW,
    parameter int DW       = SCHED_DW,
    parameter int TW       = SCHED_TW,
    parameter int DEF_HALF = SCHED_DEF_HALF
) (
    input  logic                          eclk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          halt_req,
    input  logic                          cfg_we,
    input  logic [idxWidth(NUM_CLKS)-1:0] cfg_idx,
    input  logic [HW-1:0]                 cfg_half,
    input  logic [NUM_CLKS-1:0]           cfg_en_mask,
    output logic                          step_valid,
    output logic [DW-1:0]                 step_delta,
    input  logic                          step_ready,
    output logic [NUM_CLKS-1:0]           clk_out,
    output logic [TW-1:0]                 sim_time,
`ifdef IXC_CLK_SCHED_STOP_EN
    input  logic [TW-1:0]                 stop_time,
    output logic                          stop_hit,
`endif
    output logic                          running
);

    localparam int IW = idxWidth(NUM_CLKS);

    schedState_t                 state, stateNext;
    logic [NUM_CLKS-1:0][HW-1:0] half, rem, remDec;
    logic [NUM_CLKS-1:0]         enMask, clkLvl;
    logic [TW-1:0]               simTime, timeNext;
    logic [DW-1:0]               stepDelta, deltaCalc;
    logic [HW-1:0]               minRem;
    logic                        anyEn;
    logic                        haltSeen;   // halt_req observed since CALC
    logic                        stopNow;    // CALC: stop already reached
    logic                        stopReach;  // APPLY: this step lands on stop

    ixc_clk_min_tree #(
        .NUM_CLKS (NUM_CLKS),
        .HW       (HW)
    ) u_min_tree (
        .remVec (rem),
        .enMask (enMask),
        .minVal (minRem),
        .anyEn  (anyEn)
    );

    // The registered delta never exceeds a remaining count, so its low HW
    // bits are the whole decrement.
    always_comb begin
        for (int i = 0; i < NUM_CLKS; i++) begin
            remDec[i] = rem[i] - stepDelta[HW-1:0];
        end
        timeNext = simTime + TW'(stepDelta);
    end

`ifdef IXC_CLK_SCHED_STOP_EN
    logic [TW-1:0] gapTime;
    logic          stopHitQ;

    // Clip the step to the distance to stop_time; when clipped, the value is
    // below minRem and therefore fits in the delta width.
    always_comb begin
        gapTime   = stop_time - simTime;
        stopNow   = (stop_time <= simTime);
        stopReach = (timeNext == stop_time);
        if (gapTime < TW'(minRem)) begin
            deltaCalc = gapTime[DW-1:0];
        end else begin
            deltaCalc = DW'(minRem);
        end
    end

    always_ff @(posedge eclk) begin
        if (rst) begin
            stopHitQ <= 1'b0;
        end else begin
            stopHitQ <= ((state == CALC) && stopNow) ||
                        ((state == APPLY) && stopReach);
        end
    end

    assign stop_hit = stopHitQ;
`else
    always_comb begin
        stopNow   = 1'b0;
        stopReach = 1'b0;
        deltaCalc = DW'(minRem);
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge eclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = CALC;
            CALC:    stateNext = (stopNow || !anyEn) ? IDLE : ISSUE;
            ISSUE:   if (step_ready) stateNext = APPLY;
            APPLY:   stateNext = (haltSeen || halt_req || stopReach) ? IDLE : CALC;
            default: stateNext = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        step_valid = (state == ISSUE);
        running    = (state != IDLE);
        step_delta = stepDelta;
        clk_out    = clkLvl;
        sim_time   = simTime;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge eclk) begin
        if (rst) begin
            // NOTE: the half/rem arrays are a handful of flops with defined
            // reset values, so they are reset here like any other register
            // rather than left uninitialised as a RAM would be.
            for (int i = 0; i < NUM_CLKS; i++) begin
                half[i] <= HW'(DEF_HALF);
                rem[i]  <= '0;
            end
            enMask    <= '0;
            clkLvl    <= '0;
            simTime   <= '0;
            stepDelta <= '0;
            haltSeen  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    for (int i = 0; i < NUM_CLKS; i++) begin
                        if (cfg_we && (cfg_idx == IW'(i))) begin
                            half[i] <= (cfg_half == '0) ? HW'(1) : cfg_half;
                        end
                    end
                    if (start) begin
                        enMask <= cfg_en_mask;
                        for (int i = 0; i < NUM_CLKS; i++) begin
                            rem[i] <= half[i];
                        end
                    end
                end
                CALC: begin
                    haltSeen <= halt_req;
                    if (!stopNow && anyEn) begin
                        stepDelta <= deltaCalc;
                    end
                end
                ISSUE: begin
                    haltSeen <= haltSeen | halt_req;
                end
                APPLY: begin
                    // Disabled clocks keep both level and remaining count.
                    for (int i = 0; i < NUM_CLKS; i++) begin
                        if (enMask[i]) begin
                            if (remDec[i] == '0) begin
                                clkLvl[i] <= ~clkLvl[i];
                                rem[i]    <= half[i];
                            end else begin
                                rem[i]    <= remDec[i];
                            end
                        end
                    end
                    simTime <= timeNext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ixc_clock_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ixc_clock_scheduler
//   Self-checking bench for ixc_clock_scheduler. Expected steps (delta,
//   clock levels and sim_time after the step) are pushed to a scoreboard
//   when a run is started and popped as the DUT offers each step.
//   Define IXC_CLK_SCHED_STOP_EN to also exercise the stop-time feature.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ixc_clock_scheduler;

    localparam int NUM_CLKS = 4;
    localparam int HW       = 10;
    localparam int DW       = 11;
    localparam int TW       = 48;
    localparam int IW       = 2;

    logic                eclk = 1'b0;
    logic                rst;
    logic                start;
    logic                halt_req;
    logic                cfg_we;
    logic [IW-1:0]       cfg_idx;
    logic [HW-1:0]       cfg_half;
    logic [NUM_CLKS-1:0] cfg_en_mask;
    logic                step_valid;
    logic [DW-1:0]       step_delta;
    logic                step_ready;
    logic [NUM_CLKS-1:0] clk_out;
    logic [TW-1:0]       sim_time;
    logic                running;
`ifdef IXC_CLK_SCHED_STOP_EN
    logic [TW-1:0]       stop_time;
    logic                stop_hit;
`endif

    typedef struct packed {
        logic [DW-1:0]       delta;
        logic [NUM_CLKS-1:0] clk;
        logic [TW-1:0]       t;
    } expStep_t;

    expStep_t sb[$];
    int       checks = 0;
    int       errors = 0;

    always #5 eclk = ~eclk;

    ixc_clock_scheduler #(
        .NUM_CLKS (NUM_CLKS),
        .HW       (HW),
        .DW       (DW),
        .TW       (TW),
        .DEF_HALF (625)
    ) dut (
        .eclk        (eclk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_half    (cfg_half),
        .cfg_en_mask (cfg_en_mask),
        .step_valid  (step_valid),
        .step_delta  (step_delta),
        .step_ready  (step_ready),
        .clk_out     (clk_out),
        .sim_time    (sim_time),
`ifdef IXC_CLK_SCHED_STOP_EN
        .stop_time   (stop_time),
        .stop_hit    (stop_hit),
`endif
        .running     (running)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge eclk);
        @(negedge eclk);
    endtask

    task automatic pushExp(input int d, input logic [NUM_CLKS-1:0] c, input longint t);
        expStep_t e;
        e.delta = DW'(d);
        e.clk   = c;
        e.t     = TW'(t);
        sb.push_back(e);
    endtask

    task automatic doReset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_valid",   step_valid, 0);
        check("rst_delta",   step_delta, 0);
        check("rst_clk",     clk_out,    0);
        check("rst_time",    sim_time,   0);
        check("rst_running", running,    0);
`ifdef IXC_CLK_SCHED_STOP_EN
        check("rst_stop_hit", stop_hit, 0);
`endif
    endtask

    task automatic writeHalf(input int idx, input int val);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_half = HW'(val);
        cycle();
        cfg_we   = 1'b0;
    endtask

    // Leaves the DUT in CALC at a negedge.
    task automatic startRun(input logic [NUM_CLKS-1:0] mask);
        cfg_en_mask = mask;
        start       = 1'b1;
        cycle();
        start       = 1'b0;
    endtask

    task automatic waitValid(output bit ok);
        int n = 0;
        while (!step_valid && n < 50) begin
            cycle();
            n++;
        end
        ok = step_valid;
        check("step_valid_seen", step_valid, 1);
    endtask

    // Completes one step with step_ready high and compares against the
    // scoreboard. With lastStep set, halt_req is raised for this step.
    task automatic doStep(input bit lastStep);
        bit       ok;
        expStep_t e;
        if (lastStep) halt_req = 1'b1;
        waitValid(ok);
        if (ok) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("step_delta", step_delta, e.delta);
                cycle();            // handshake -> APPLY
                halt_req = 1'b0;
                cycle();            // APPLY executes
                check("clk_out",  clk_out,  e.clk);
                check("sim_time", sim_time, e.t);
            end
        end
        halt_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst         = 1'b0;
        start       = 1'b0;
        halt_req    = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_half    = '0;
        cfg_en_mask = '0;
        step_ready  = 1'b1;
`ifdef IXC_CLK_SCHED_STOP_EN
        stop_time   = '1;
`endif
        @(negedge eclk);

        // T1: default half-period, single clock, start-to-valid latency.
        doReset();
        pushExp(625, 4'b0001, 625);
        pushExp(625, 4'b0000, 1250);
        startRun(4'b0001);
        check("t1_running",     running,    1);
        check("t1_valid_cyc1",  step_valid, 0);
        cycle();
        check("t1_valid_cyc2",  step_valid, 1);
        doStep(1'b0);
        doStep(1'b1);
        check("t1_idle", running, 0);

        // T2: two clocks with different half-periods.
        doReset();
        writeHalf(0, 3);
        writeHalf(1, 5);
        pushExp(3, 4'b0001, 3);
        pushExp(2, 4'b0011, 5);
        pushExp(1, 4'b0010, 6);
        pushExp(3, 4'b0011, 9);
        pushExp(1, 4'b0001, 10);
        startRun(4'b0011);
        for (int i = 0; i < 4; i++) doStep(1'b0);
        doStep(1'b1);
        check("t2_idle", running, 0);

        // T3: tie toggles both clocks; then half=0 behaves as 1.
        doReset();
        writeHalf(0, 4);
        writeHalf(1, 4);
        pushExp(4, 4'b0011, 4);
        startRun(4'b0011);
        doStep(1'b1);
        check("t3_idle", running, 0);
        writeHalf(0, 0);
        pushExp(1, 4'b0010, 5);
        pushExp(1, 4'b0011, 6);
        startRun(4'b0001);
        doStep(1'b0);
        doStep(1'b1);

        // Empty mask: no step, straight back to IDLE.
        doReset();
        startRun(4'b0000);
        cycle();
        check("empty_running", running,    0);
        check("empty_valid",   step_valid, 0);
        cycle();
        check("empty_valid2",  step_valid, 0);

        // T4: backpressure holds the step; halt during the wait.
        doReset();
        step_ready = 1'b0;
        pushExp(625, 4'b0001, 625);
        startRun(4'b0001);
        waitValid(ok);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", step_valid, 1);
            check("t4_hold_delta", step_delta, 625);
            check("t4_hold_clk",   clk_out,    0);
            check("t4_hold_time",  sim_time,   0);
            halt_req = (i == 4);
            cycle();
        end
        halt_req   = 1'b0;
        step_ready = 1'b1;
        doStep(1'b0);
        check("t4_running", running,    0);
        cycle();
        check("t4_valid",   step_valid, 0);

        // T5: config/start while running are ignored; rst in ISSUE.
        doReset();
        writeHalf(0, 3);
        step_ready = 1'b0;
        pushExp(3, 4'b0001, 3);
        pushExp(3, 4'b0000, 6);
        startRun(4'b0001);
        cfg_we      = 1'b1;
        cfg_idx     = 2'd0;
        cfg_half    = 10'd7;
        cfg_en_mask = 4'b0011;
        start       = 1'b1;
        cycle();
        cfg_we      = 1'b0;
        start       = 1'b0;
        step_ready  = 1'b1;
        doStep(1'b0);
        doStep(1'b0);
        step_ready = 1'b0;
        waitValid(ok);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_rst_valid",   step_valid, 0);
        check("t5_rst_clk",     clk_out,    0);
        check("t5_rst_time",    sim_time,   0);
        check("t5_rst_running", running,    0);
        step_ready = 1'b1;
        pushExp(625, 4'b0001, 625);
        startRun(4'b0001);
        doStep(1'b1);

`ifdef IXC_CLK_SCHED_STOP_EN
        // T6: stop time clips the second step and ends scheduling.
        doReset();
        stop_time = 48'd7;
        writeHalf(0, 5);
        pushExp(5, 4'b0001, 5);
        pushExp(2, 4'b0001, 7);
        startRun(4'b0001);
        doStep(1'b0);
        doStep(1'b0);
        check("t6_stop_hit",  stop_hit, 1);
        check("t6_running",   running,  0);
        cycle();
        check("t6_stop_pulse", stop_hit, 0);
        startRun(4'b0001);
        check("t6_calc_hit",  stop_hit, 0);
        cycle();
        check("t6_imm_hit",   stop_hit,   1);
        check("t6_imm_valid", step_valid, 0);
        check("t6_imm_run",   running,    0);
        stop_time = '1;
`endif

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
